// File: rtl/cp_remove.sv
// Purpose: receive-side cyclic-prefix removal; drops CP_LEN prefix samples, forwards N_FFT useful samples with fresh framing.
// Latency: 1 cycle from an accepted sample (en=1) to its output; all outputs registered.
// Backpressure: none; sample-strobe driven (en), sustains one sample per clock, en=0 freezes state and strobes.
//
// Ports:
//   clk, rst (async, active-low)
//   en, in_sop, in_i, in_q          : input sample stream, in_sop marks CP sample 0
//   out_i, out_q, valid_out         : useful samples, data held while valid_out=0
//   sop_out, eop_out                : first / last useful sample of a symbol
//   sync_err                        : in_sop seen while a symbol was still in progress
module cp_remove #(
    parameter int N_FFT  = 64,
    parameter int CP_LEN = 16,
    parameter int W      = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                in_sop,
    input  logic signed [W-1:0] in_i,
    input  logic signed [W-1:0] in_q,
    output logic signed [W-1:0] out_i,
    output logic signed [W-1:0] out_q,
    output logic                valid_out,
    output logic                sop_out,
    output logic                eop_out,
    output logic                sync_err
);

    localparam int CW = $clog2(N_FFT);

    // Compare constants sized to the counter; CP_LEN < N_FFT so both fit.
    localparam logic [CW-1:0] CP_LAST  = CW'(CP_LEN - 1);
    localparam logic [CW-1:0] FFT_LAST = CW'(N_FFT - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SKIP = 2'd1,
        PASS = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic signed [W-1:0] out_i_q, out_i_d;
    logic signed [W-1:0] out_q_q, out_q_d;
    logic                vld_q, vld_d;
    logic                sop_q, sop_d;
    logic                eop_q, eop_d;
    logic                err_q, err_d;

    // Next-state and registered-output logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        out_i_d = out_i_q;
        out_q_d = out_q_q;
        vld_d   = 1'b0;
        sop_d   = 1'b0;
        eop_d   = 1'b0;
        err_d   = 1'b0;

        if (en) begin
            if (in_sop) begin
                // A start pulse is always CP sample 0. Outside IDLE it means
                // the partial symbol is abandoned without an eop.
                err_d = (state_q != IDLE);
                if (CP_LEN == 1) begin
                    state_d = PASS;
                    cnt_d   = '0;
                end else begin
                    state_d = SKIP;
                    cnt_d   = CNT_ONE;
                end
            end else begin
                case (state_q)
                    IDLE: begin
                        // Samples with no symbol in progress are discarded.
                        state_d = IDLE;
                    end
                    SKIP: begin
                        if (cnt_q == CP_LAST) begin
                            state_d = PASS;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end
                    PASS: begin
                        vld_d   = 1'b1;
                        out_i_d = in_i;
                        out_q_d = in_q;
                        sop_d   = (cnt_q == '0);
                        eop_d   = (cnt_q == FFT_LAST);
                        if (cnt_q == FFT_LAST) begin
                            state_d = IDLE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end
                    default: begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            out_i_q <= '0;
            out_q_q <= '0;
            vld_q   <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_i_q <= out_i_d;
            out_q_q <= out_q_d;
            vld_q   <= vld_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
            err_q   <= err_d;
        end
    end

    assign out_i     = out_i_q;
    assign out_q     = out_q_q;
    assign valid_out = vld_q;
    assign sop_out   = sop_q;
    assign eop_out   = eop_q;
    assign sync_err  = err_q;

endmodule

// File: doc/cp_remove.md
# cp_remove

Receive-side cyclic-prefix removal for the OFDM modem. Takes a sample stream of CP_LEN + N_FFT samples per symbol, marked by a start-of-symbol pulse on the first prefix sample. Discards the prefix and forwards the N_FFT useful samples with fresh sop/eop/valid framing. Sits between the receive front end and the FFT; it is the inverse of the transmit-side CP insertion stage.

## Interface
- N_FFT, 64, useful samples per symbol (power of two, ≥ 4)
- CP_LEN, 16, prefix samples per symbol (1 ≤ CP_LEN < N_FFT)
- W, 16, sample width per rail (signed)

- clk  in  1  clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- en  in  1  sample strobe; one input sample consumed per cycle with en=1
- in_sop  in  1  first prefix sample of a symbol; qualified by en
- in_i, in_q  in  W  signed I/Q sample; qualified by en
- out_i, out_q  out  W  signed I/Q useful sample
- valid_out  out  1  out_i/out_q carry a useful sample this cycle
- sop_out  out  1  first useful sample of the symbol; only with valid_out
- eop_out  out  1  last (N_FFT-th) useful sample; only with valid_out
- sync_err  out  1  one-cycle pulse: in_sop arrived before the current symbol completed

## Operation
- FSM states: IDLE, SKIP, PASS. One counter cnt, width clog2(N_FFT).
- Only cycles with en=1 are sample events. With en=0: state and cnt hold, and no output strobes assert.
- IDLE: an en-cycle without in_sop is discarded. An en-cycle with in_sop is CP sample 0: set cnt=1. Go to SKIP, or to PASS with cnt=0 if CP_LEN==1.
- SKIP: discard the sample and increment cnt. On the sample where cnt==CP_LEN-1, clear cnt and go to PASS.
- PASS: forward the sample and increment cnt.
  - sop_out accompanies cnt==0.
  - eop_out accompanies cnt==N_FFT-1; that sample returns the FSM to IDLE with cnt=0.
- Back-to-back symbols: an in_sop on the en-cycle right after the eop sample is handled normally from IDLE. No gap is required.
- Resync: in_sop with en in SKIP or PASS (not an expected position):
  - pulse sync_err;
  - drop the partial symbol, with no further outputs for it and no eop_out;
  - treat the sample as CP sample 0, exactly as in IDLE.
- Samples pass unmodified: no scaling, rounding or reordering.

## Timing
- Reset (rst=0, asynchronous): state=IDLE, cnt=0. out_i, out_q, valid_out, sop_out, eop_out and sync_err are all 0. Takes effect immediately and overrides a symbol in progress.
- Latency: 1 cycle. A sample accepted at edge k appears on the outputs after edge k, valid for one cycle.
- All outputs are registered.
- valid_out, sop_out, eop_out and sync_err are single-cycle strobes and drop when the next cycle has no event.
- out_i/out_q hold their last value when valid_out=0.
- sync_err asserts 1 cycle after the offending in_sop, the same cycle the output of that sample would appear.
- Throughput: one sample per clock sustained. Output duty cycle is N_FFT/(N_FFT+CP_LEN) with continuous en.
- After reset release, nothing is output until the first in_sop.

## Test plan
- Single symbol, en held high, defaults. 80 samples, in_i = index 0..79, in_q = -index, in_sop on index 0.
  - Required: valid_out for exactly 64 cycles, carrying in_i 16..63+16 = 16..79.
  - sop_out with in_i=16, eop_out with in_i=79.
  - First valid_out appears 1 cycle after sample 16 is accepted.
- Three back-to-back symbols, no gaps, 240 samples.
  - Required: 3×64 outputs, 3 sop_out and 3 eop_out pulses, sync_err never asserts.
- en toggled 1,0,1,0 across one symbol.
  - Required: identical output values and order to the first scenario.
  - No strobe in any cycle following an en=0 input cycle.
- in_sop reasserted at sample 40 (in PASS).
  - Required: sync_err pulse, no eop_out for the aborted symbol.
  - A new full 64-sample symbol follows, starting with sample 40+16 of the new stream.
- Reset asserted at sample 50 of a symbol.
  - Required: all outputs go to 0 asynchronously and no output appears until a new in_sop.
  - Samples without in_sop after reset release are discarded.
- CP_LEN=1, N_FFT=4, one symbol of 5 samples.
  - Required: samples 1..4 are output, sop_out on sample 1, eop_out on sample 4.
